// File: rtl/aes_dec_pipe_ctrl.sv
// Sequencing controller for an 11-stage pipelined AES-128 decryption datapath.
// It runs the round-key load sequence and gates ciphertext blocks into the
// pipeline. It also carries a valid/tag token alongside every block. On a key
// change it waits for all in-flight blocks to leave the pipeline before it
// reloads the round keys, so no block ever sees a mix of old and new keys.
module aes_dec_pipe_ctrl #(
    parameter int STAGES     = 11,
    parameter int KEY_CYCLES = 11,
    parameter int TAG_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [127:0]       key_in,
    output logic [127:0]       key_out,
    output logic               key_gen_en,
    output logic [3:0]         round_count,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               dp_in_valid,
    output logic               out_valid,
    output logic [TAG_W-1:0]   out_tag,
    output logic               keys_loaded,
    output logic               busy
);

    localparam int         OCC_W   = $clog2(STAGES + 1);
    localparam logic [3:0] RC_LAST = 4'(KEY_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_KEYLOAD = 2'd1,
        ST_RUN     = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [127:0]       key_q, key_d;
    logic [3:0]         rc_q, rc_d;
    logic               kge_q, kge_d;
    logic               kl_q, kl_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [STAGES-1:0]  vld_q;
    logic [TAG_W-1:0]   tag_q [STAGES];

    logic               accept_s;
    logic               key_hs_s;

    // Handshake readiness depends only on the current state.
    always_comb begin
        key_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
        in_ready  = (state_q == ST_RUN);
        accept_s  = in_valid & in_ready;
        key_hs_s  = key_valid & key_ready;
    end

    // Next-state logic for the key-load / run / drain sequencer.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rc_d    = rc_q;
        kge_d   = kge_q;
        kl_d    = kl_q;
        case (state_q)
            ST_IDLE: begin
                if (key_hs_s) begin
                    key_d   = key_in;
                    rc_d    = 4'd1;
                    kge_d   = 1'b1;
                    state_d = ST_KEYLOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KEYLOAD: begin
                if (rc_q == RC_LAST) begin
                    rc_d    = 4'd0;
                    kge_d   = 1'b0;
                    kl_d    = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    rc_d    = rc_q + 4'd1;
                end
            end
            ST_RUN: begin
                // The block accepted in this same cycle still completes
                // with the old round keys, because the drain waits for it.
                if (key_hs_s) begin
                    key_d   = key_in;
                    kl_d    = 1'b0;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (occ_q == '0) begin
                    rc_d    = 4'd1;
                    kge_d   = 1'b1;
                    state_d = ST_KEYLOAD;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The pipeline occupancy goes up when a block enters and down when a block leaves.
    always_comb begin
        occ_d = occ_q;
        case ({accept_s, out_valid})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Sequencer, key latch and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= 128'd0;
            rc_q    <= 4'd0;
            kge_q   <= 1'b0;
            kl_q    <= 1'b0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
            kge_q   <= kge_d;
            kl_q    <= kl_d;
            occ_q   <= occ_d;
        end
    end

    // The token shift register runs in step with the datapath stages and never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q    <= {vld_q[STAGES-2:0], accept_s};
            tag_q[0] <= in_tag;
            for (int i = 1; i < STAGES; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Drive the outputs from the registered state.
    always_comb begin
        key_out     = key_q;
        round_count = rc_q;
        key_gen_en  = kge_q;
        keys_loaded = kl_q;
        dp_in_valid = accept_s;
        out_valid   = vld_q[STAGES-1];
        out_tag     = tag_q[STAGES-1];
        busy        = (state_q != ST_IDLE) || (occ_q != '0);
    end

    // The occupancy counter must stay within 0..STAGES.
    a_occ_range: assert property (@(posedge clk) disable iff (rst)
        occ_q <= OCC_W'(STAGES));
    a_occ_over: assert property (@(posedge clk) disable iff (rst)
        !(accept_s && !out_valid && occ_q == OCC_W'(STAGES)));
    a_occ_under: assert property (@(posedge clk) disable iff (rst)
        !(out_valid && !accept_s && occ_q == '0));

endmodule

// File: tb/tb_aes_dec_pipe_ctrl.sv
// Self-checking bench for aes_dec_pipe_ctrl. A scoreboard holds the expected
// tag and the due cycle of every block. The block is pushed when it is
// accepted and popped when out_valid should appear.
module tb_aes_dec_pipe_ctrl;

    localparam int STAGES     = 11;
    localparam int KEY_CYCLES = 11;
    localparam int TAG_W      = 4;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K3 = 128'hdeadbeef0123456789abcdeffedcba98;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             key_valid = 1'b0;
    logic             key_ready;
    logic [127:0]     key_in = 128'd0;
    logic [127:0]     key_out;
    logic             key_gen_en;
    logic [3:0]       round_count;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [TAG_W-1:0] in_tag = '0;
    logic             dp_in_valid;
    logic             out_valid;
    logic [TAG_W-1:0] out_tag;
    logic             keys_loaded;
    logic             busy;

    aes_dec_pipe_ctrl #(.STAGES(STAGES), .KEY_CYCLES(KEY_CYCLES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in), .key_out(key_out),
        .key_gen_en(key_gen_en), .round_count(round_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .dp_in_valid(dp_in_valid), .out_valid(out_valid), .out_tag(out_tag),
        .keys_loaded(keys_loaded), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    int   peak  = 0;
    logic trk   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (trk && int'(dut.occ_q) > peak) peak <= int'(dut.occ_q);

    // Scoreboard monitor: each expected block must appear exactly on its due cycle
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_missed: tag %0d due cycle %0d not delivered (now %0d)",
                         sb[0].tag, sb[0].due, cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                n_cmp++;
                if (out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL out_valid_due: cycle %0d got %b expected 1", cyc, out_valid);
                end
                n_cmp++;
                if (out_tag !== sb[0].tag) begin
                    n_bad++;
                    $display("FAIL out_tag: cycle %0d got %0d expected %0d", cyc, out_tag, sb[0].tag);
                end
                n_out++;
                void'(sb.pop_front());
            end else if (out_valid !== 1'b0) begin
                n_cmp++; n_bad++;
                $display("FAIL out_valid_spurious: cycle %0d got %b expected 0", cyc, out_valid);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d blocks left after %0d cycles, expected 0", sb.size(), budget);
            sb.delete();
        end
        tick();
    endtask

    task automatic test_reset;
        logic [14:0] obs;
        rst = 1'b1; key_valid = 1'b0; in_valid = 1'b0;
        #3;
        obs = {round_count, key_gen_en, keys_loaded, out_valid, out_tag, busy, key_ready, in_ready, dp_in_valid};
        n_cmp++;
        if (obs !== 15'b0000_0_0_0_0000_0_1_0_0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 15'b0000_0_0_0_0000_0_1_0_0);
        end
        n_cmp++;
        if (key_out !== 128'd0) begin
            n_bad++;
            $display("FAIL reset_key_out: got %h expected 0", key_out);
        end
        @(negedge clk);
        rst = 1'b0;
        // in_valid in IDLE must not be accepted
        in_valid = 1'b1; in_tag = 4'hA;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (dp_in_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_no_accept: dp_in_valid=%b in_ready=%b busy=%b expected 0/0/0",
                         dp_in_valid, in_ready, busy);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Checks the KEYLOAD sequence starting at a negedge where round_count should be 1
    task automatic check_keyload(input logic [127:0] key, input logic hold_valid);
        for (int i = 1; i <= KEY_CYCLES; i++) begin
            n_cmp++;
            if (round_count !== 4'(i) || key_gen_en !== 1'b1 || keys_loaded !== 1'b0 ||
                in_ready !== 1'b0 || key_ready !== 1'b0 || key_out !== key) begin
                n_bad++;
                $display("FAIL keyload_step%0d: rc=%0d kge=%b kl=%b in_rdy=%b key_rdy=%b expected rc=%0d kge=1 kl=0 in_rdy=0 key_rdy=0",
                         i, round_count, key_gen_en, keys_loaded, in_ready, key_ready, i);
            end
            if (hold_valid) begin
                n_cmp++;
                if (dp_in_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL keyload_no_accept: step %0d dp_in_valid=%b expected 0", i, dp_in_valid);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (round_count !== 4'd0 || key_gen_en !== 1'b0 || keys_loaded !== 1'b1 ||
            in_ready !== 1'b1 || key_ready !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL keyload_done: rc=%0d kge=%b kl=%b in_rdy=%b key_rdy=%b busy=%b expected 0/0/1/1/1/1",
                     round_count, key_gen_en, keys_loaded, in_ready, key_ready, busy);
        end
    endtask

    task automatic test_keyload(input logic [127:0] key);
        key_in = key; key_valid = 1'b1;
        #1;
        n_cmp++;
        if (key_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL key_ready_idle: got %b expected 1", key_ready);
        end
        tick();
        key_valid = 1'b0;
        check_keyload(key, 1'b0);
    endtask

    task automatic test_single(input logic [TAG_W-1:0] tag);
        int o0 = n_out;
        @(negedge clk);
        in_valid = 1'b1; in_tag = tag;
        #1;
        n_cmp++;
        if (dp_in_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL single_accept: dp_in_valid=%b expected 1", dp_in_valid);
        end
        sb.push_back('{tag: tag, due: cyc + STAGES});
        tick();
        in_valid = 1'b0;
        wait_drain(3 * STAGES);
        n_cmp++;
        if (n_out - o0 !== 1) begin
            n_bad++;
            $display("FAIL single_count: outputs %0d expected 1", n_out - o0);
        end
    endtask

    task automatic test_back_to_back;
        int o0 = n_out;
        peak = 0; trk = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_tag = 4'(i % 16);
            #1;
            n_cmp++;
            if (dp_in_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_accept: block %0d dp_in_valid=%b expected 1", i, dp_in_valid);
            end
            sb.push_back('{tag: 4'(i % 16), due: cyc + STAGES});
            tick();
        end
        in_valid = 1'b0;
        wait_drain(3 * STAGES);
        trk = 1'b0;
        n_cmp++;
        if (n_out - o0 !== 20) begin
            n_bad++;
            $display("FAIL b2b_count: outputs %0d expected 20", n_out - o0);
        end
        n_cmp++;
        if (peak !== STAGES) begin
            n_bad++;
            $display("FAIL b2b_peak_occ: got %0d expected %0d", peak, STAGES);
        end
        n_cmp++;
        if (dut.occ_q !== 4'd0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_final: occ=%0d busy=%b expected 0/1", dut.occ_q, busy);
        end
    endtask

    task automatic test_key_change;
        int o0 = n_out;
        int c7;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_tag = 4'(8 + i);
            #1;
            sb.push_back('{tag: 4'(8 + i), due: cyc + STAGES});
            tick();
        end
        // seventh block shares its cycle with the key handshake
        in_valid = 1'b1; in_tag = 4'hE; key_valid = 1'b1; key_in = K2;
        #1;
        n_cmp++;
        if (dp_in_valid !== 1'b1 || key_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL kc_handshake: dp_in_valid=%b key_ready=%b expected 1/1", dp_in_valid, key_ready);
        end
        sb.push_back('{tag: 4'hE, due: cyc + STAGES});
        c7 = cyc;
        tick();
        key_valid = 1'b0; in_tag = 4'h3;
        n_cmp++;
        if (keys_loaded !== 1'b0 || key_out !== K2 || key_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL kc_enter_drain: kl=%b key_rdy=%b key_out=%h expected 0/0/%h",
                     keys_loaded, key_ready, key_out, K2);
        end
        while (cyc <= c7 + STAGES + 1) begin
            n_cmp++;
            if (in_ready !== 1'b0 || dp_in_valid !== 1'b0 || round_count !== 4'd0 || key_gen_en !== 1'b0) begin
                n_bad++;
                $display("FAIL kc_drain: cycle %0d in_rdy=%b dp_in_valid=%b rc=%0d kge=%b expected 0/0/0/0",
                         cyc, in_ready, dp_in_valid, round_count, key_gen_en);
            end
            tick();
        end
        n_cmp++;
        if (n_out - o0 !== 7 || sb.size() !== 0) begin
            n_bad++;
            $display("FAIL kc_old_key_outputs: got %0d (pending %0d) expected 7 (pending 0)", n_out - o0, sb.size());
        end
        check_keyload(K2, 1'b1);
        test_single(4'h9);
    endtask

    task automatic test_reset_abort;
        logic [14:0] obs;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        key_in = K3; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (round_count !== 4'd6) begin
            n_bad++;
            $display("FAIL abort_pre_rc: got %0d expected 6", round_count);
        end
        #2 rst = 1'b1;
        #1;
        obs = {round_count, key_gen_en, keys_loaded, out_valid, out_tag, busy, key_ready, in_ready, dp_in_valid};
        n_cmp++;
        if (obs !== 15'b0000_0_0_0_0000_0_1_0_0 || key_out !== 128'd0) begin
            n_bad++;
            $display("FAIL abort_async: got %b key_out=%h expected %b key_out=0",
                     obs, key_out, 15'b0000_0_0_0_0000_0_1_0_0);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (keys_loaded !== 1'b0 || key_ready !== 1'b1 || in_ready !== 1'b0 ||
                dp_in_valid !== 1'b0 || busy !== 1'b0 || key_gen_en !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_idle: kl=%b key_rdy=%b in_rdy=%b dp=%b busy=%b kge=%b expected 0/1/0/0/0/0",
                         keys_loaded, key_ready, in_ready, dp_in_valid, busy, key_gen_en);
            end
        end
        in_valid = 1'b0;
        test_keyload(K1);
        test_single(4'h7);
    endtask

    initial begin
        test_reset();
        test_keyload(K1);
        test_single(4'h5);
        test_back_to_back();
        test_key_change();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/aes_dec_pipe_ctrl.md
Name: aes_dec_pipe_ctrl

Overview:
- Sequencing controller for the 11-stage pipelined AES-128 decryption datapath.
- Owns the round-key load sequence that drives the key generator enable and round counter. The datapath's k0..k10 registers capture on round counts 1..11.
- Gates ciphertext blocks into the pipeline with a valid/ready handshake and tracks a valid/tag token alongside each block, producing out_valid/out_tag.
- On a key change, drains in-flight blocks before reloading keys, so no block is ever decrypted with mixed keys.

Parameters:
- STAGES, 11, pipeline latency in cycles (round10..round0 registered stages).
- KEY_CYCLES, 11, round-key load cycles (round_count 1..KEY_CYCLES).
- TAG_W, 4, width of the user tag carried with each block.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- key_valid  in  1  new key offered.
- key_ready  out  1  controller can accept a key this cycle.
- key_in  in  128  cipher key.
- key_out  out  128  latched key to the datapath KEY input.
- key_gen_en  out  1  key generator enable.
- round_count  out  4  round counter to key generator and k-register enables.
- in_valid  in  1  ciphertext block offered.
- in_ready  out  1  block accepted when in_valid & in_ready.
- in_tag  in  TAG_W  user tag for the block.
- dp_in_valid  out  1  qualifier of the block presented to the datapath IN this cycle.
- out_valid  out  1  datapath OUT holds a valid plaintext.
- out_tag  out  TAG_W  tag of that plaintext.
- keys_loaded  out  1  round-key set valid.
- busy  out  1  state != IDLE or occupancy != 0.

Behaviour:
- Reset (async, active-high): state=IDLE, key_out=0, round_count=0, key_gen_en=0, keys_loaded=0, valid/tag shift register cleared, occupancy=0, out_valid=0, out_tag=0. A reset mid-operation aborts KEYLOAD/DRAIN; the partially loaded key set is treated invalid.
- States: IDLE, KEYLOAD, RUN, DRAIN.
- key_ready=1 in IDLE and RUN only. in_ready=1 only in RUN. Both are combinational from state.
- IDLE: on key handshake, latch key_out<=key_in, round_count<=1, key_gen_en<=1, go KEYLOAD.
- KEYLOAD:
  - round_count increments by 1 each cycle from 1 to KEY_CYCLES, with key_gen_en=1 throughout.
  - On the cycle round_count==KEY_CYCLES, next cycle: round_count<=0, key_gen_en<=0, keys_loaded<=1, state<=RUN.
  - Key and data handshakes are ignored in this state.
- RUN:
  - Accepts blocks every cycle (full throughput).
  - Accept = in_valid & in_ready.
  - dp_in_valid = accept (combinational).
  - Token shift register: stage0<={accept,in_tag}, stage i<=stage i-1. out_valid/out_tag come from stage STAGES-1.
  - Latency: a block accepted at edge T gives out_valid=1 in the cycle after edge T+STAGES-1, i.e. STAGES cycles after acceptance.
  - On key handshake in RUN: latch key_out, keys_loaded<=0, go DRAIN. A data handshake in the same cycle is also accepted and completes under the old key.
- DRAIN:
  - in_ready=0.
  - The shift register keeps advancing and key_out keeps its newly latched value; datapath k-registers are untouched until KEYLOAD.
  - When occupancy==0 (registered), round_count<=1, key_gen_en<=1, go KEYLOAD.
- Occupancy counter, 0..STAGES:
  - +1 on accept, -1 on out_valid, unchanged when both occur.
  - Never exceeds STAGES by construction. Overflow or underflow is an assertion failure.
- busy as defined above. busy=0 only in IDLE with empty pipeline; after the first key, the controller never returns to IDLE except via reset.
- The datapath IN is wired directly from the data source. The controller never stalls the pipeline; bubbles are marked by a 0 token.

Test Plan:
1. Reset release, then key_valid with key 000102030405060708090a0b0c0d0e0f at cycle 0 -> round_count 1,2,…,11 on cycles 1..11 with key_gen_en=1; cycle 12: round_count=0, keys_loaded=1, in_ready=1.
2. After load, present ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a with tag 5 -> out_valid exactly 11 cycles later, datapath OUT=00112233445566778899aabbccddeeff, out_tag=5, pulse 1 cycle.
3. 20 back-to-back blocks with tags 0..15,0..3 -> out_valid high 20 consecutive cycles, tags in order, occupancy peaks at 11 and returns to 0.
4. Key change mid-stream after 6 blocks, with a data handshake in the same cycle -> 7 outputs with old key, in_ready=0 through drain, KEYLOAD starts on the cycle after occupancy reaches 0, next block decrypts correctly with the new key; no block lost or duplicated.
5. rst asserted at round_count=6 in KEYLOAD -> all outputs go to reset values immediately without waiting for clk; after release, state=IDLE and keys_loaded=0.
6. in_valid held high in IDLE, KEYLOAD and DRAIN -> no accept, dp_in_valid=0, no tokens inserted.
